// File: rtl/visited_arbiter.sv
// Round-robin test-and-set sequencer for a shared 1-bit visited-flag BRAM, with a sweep clear.
// Grant to response is 4 cycles; a clear takes DEPTH cycles. Only one request is granted per idle cycle.
module visited_arbiter #(
    parameter int PROC_BITS = 2,
    parameter int ADDR_BITS = 10,
    localparam int NUM_PROCS = 2**PROC_BITS
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_PROCS-1:0]           req_valid_in,
    input  logic [NUM_PROCS*ADDR_BITS-1:0] req_addr_in,
    output logic [NUM_PROCS-1:0]           req_ready_out,
    output logic [NUM_PROCS-1:0]           resp_valid_out,
    output logic                           resp_visited_out,
    input  logic                           clear_start_in,
    output logic                           clear_busy_out,
    output logic [ADDR_BITS-1:0]           mem_addr_out,
    output logic                           mem_wdata_out,
    output logic                           mem_we_out,
    input  logic                           mem_rdata_in
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [PROC_BITS-1:0]   ptr_q, ptr_d;
    logic                   pending_q, pending_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [PROC_BITS-1:0]   id_q, id_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [NUM_PROCS-1:0]   resp_valid_q, resp_valid_d;
    logic                   resp_visited_q, resp_visited_d;

    logic                   found;
    logic [PROC_BITS-1:0]   sel;
    logic [PROC_BITS-1:0]   idx;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = '0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            idx = ptr_q + PROC_BITS'(i);
            if (!found && req_valid_in[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            pending_q      <= 1'b0;
            addr_q         <= '0;
            id_q           <= '0;
            cnt_q          <= '0;
            resp_valid_q   <= '0;
            resp_visited_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            pending_q      <= pending_d;
            addr_q         <= addr_d;
            id_q           <= id_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_visited_q <= resp_visited_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        pending_d      = pending_q | clear_start_in;
        addr_d         = addr_q;
        id_d           = id_q;
        cnt_d          = cnt_q;
        resp_valid_d   = '0;
        resp_visited_d = resp_visited_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_CLEAR;
                    cnt_d     = '0;
                    pending_d = clear_start_in;
                end else if (found) begin
                    addr_d  = req_addr_in[int'(sel)*ADDR_BITS +: ADDR_BITS];
                    id_d    = sel;
                    ptr_d   = sel + PROC_BITS'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            S_CHECK: begin
                resp_valid_d[id_q] = 1'b1;
                resp_visited_d     = mem_rdata_in;
                state_d            = S_IDLE;
            end
            S_CLEAR: begin
                cnt_d = cnt_q + ADDR_BITS'(1);
                if (cnt_q == '1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_out = '0;
        if (state_q == S_IDLE && !pending_q && found) req_ready_out[sel] = 1'b1;
        mem_addr_out  = (state_q == S_CLEAR) ? cnt_q : addr_q;
        mem_we_out    = 1'b0;
        mem_wdata_out = 1'b0;
        if (state_q == S_CHECK && !mem_rdata_in) begin
            mem_we_out    = 1'b1;
            mem_wdata_out = 1'b1;
        end else if (state_q == S_CLEAR) begin
            mem_we_out = 1'b1;
        end
        // A reset arriving mid-operation must not let a write slip through.
        if (rst_in) begin
            mem_we_out    = 1'b0;
            mem_wdata_out = 1'b0;
        end
        clear_busy_out   = pending_q | (state_q == S_CLEAR);
        resp_valid_out   = resp_valid_q;
        resp_visited_out = resp_visited_q;
    end

endmodule

// File: doc/visited_arbiter.md
# visited_arbiter

Round-robin arbiter and sequencer that shares the single-port 1-bit visited-flag BRAM among `2**PROC_BITS` graph-search processors. Each granted request performs an atomic test-and-set: read the flag, set it to 1 if clear, and return the old value to the requester. A sweep controller zeroes the whole memory between searches. The block sits between the processor array and the flag BRAM (read-first, `HIGH_PERFORMANCE`, 2-cycle read latency).

## Interface

Parameters:
- `PROC_BITS`, default 2: requester index width; `NUM_PROCS = 2**PROC_BITS`.
- `ADDR_BITS`, default 10: flag memory address width; `DEPTH = 2**ADDR_BITS`.

Ports:
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `req_valid_in`  input  NUM_PROCS  per-processor test-and-set request.
- `req_addr_in`  input  NUM_PROCS*ADDR_BITS  packed vertex addresses; processor i uses slice `[i*ADDR_BITS +: ADDR_BITS]`.
- `req_ready_out`  output  NUM_PROCS  one-hot grant; a request is accepted when valid & ready.
- `resp_valid_out`  output  NUM_PROCS  one-hot, one-cycle response pulse to the granted processor.
- `resp_visited_out`  output  1  flag value before the set; meaningful only while any `resp_valid_out` bit is high.
- `clear_start_in`  input  1  one-cycle pulse requesting a full memory clear.
- `clear_busy_out`  output  1  high while a clear is pending or in progress.
- `mem_addr_out`  output  ADDR_BITS  BRAM address.
- `mem_wdata_out`  output  1  BRAM write data.
- `mem_we_out`  output  1  BRAM write enable.
- `mem_rdata_in`  input  1  BRAM registered output.

## Operation

- States: IDLE, ISSUE, WAIT, CHECK, CLEAR.
- Reset: state IDLE; round-robin pointer 0; clear_pending 0; captured addr/id 0. All outputs 0.
- `clear_start_in` sets clear_pending in any state. The pending bit is serviced at the next IDLE.
- IDLE:
  - If clear_pending: go to CLEAR, clear counter = 0, drop clear_pending. No grant is issued that cycle.
  - Else select the first asserted `req_valid_in[k]` searching k = ptr, ptr+1, … modulo NUM_PROCS.
  - `req_ready_out[k]` = 1 combinationally, the same cycle. Capture address and k. ptr <= (k+1) mod NUM_PROCS. Go to ISSUE.
  - With no request, stay in IDLE. The pointer is unchanged.
- `req_ready_out` is 0 in every state except IDLE. It is at most one-hot and never asserted toward an invalid requester.
- ISSUE: `mem_addr_out` = captured address, `mem_we_out` = 0. Go to WAIT.
- WAIT: hold the address. Go to CHECK.
- CHECK:
  - `mem_rdata_in` holds the flag for the captured address.
  - If it is 0: `mem_we_out` = 1, `mem_wdata_out` = 1, same address.
  - Register resp_visited <= rdata and resp_valid[k] <= 1. Go to IDLE.
- CLEAR:
  - `mem_we_out` = 1, `mem_wdata_out` = 0, `mem_addr_out` = counter; counter increments.
  - After address DEPTH-1 is written, go to IDLE. The counter wraps to 0.
  - A `clear_start_in` pulse during CLEAR sets clear_pending again, so one more full sweep follows.
- `clear_busy_out` = clear_pending | (state == CLEAR).
- Outside CHECK(write) and CLEAR, `mem_we_out` = 0. `mem_addr_out` holds the captured address, or the counter in CLEAR.
- Requests are serialized, so back-to-back requests to the same vertex need no forwarding. The second request always reads 1.
- Reset mid-operation aborts immediately: no response pulse and no further writes. Memory contents are unchanged. Reset does not trigger a clear.

## Timing

- Accept in cycle t (IDLE). ISSUE is t+1, WAIT t+2, CHECK t+3 (data valid, conditional write).
- `resp_valid_out` pulses in cycle t+4, exactly one cycle. The block is back in IDLE at t+4 and may grant again in that same cycle.
- Throughput is 1 operation per 4 cycles.
- Clear takes exactly DEPTH cycles in CLEAR, plus the wait for the in-flight operation to finish (≤3 cycles).
- Response registers are cleared every cycle unless set from CHECK. `resp_visited_out` holds its last value otherwise.

## Test plan

- **Reset and single request:** reset, then P0 requests addr 5 with memory all 0 → ready[0] at t; resp_valid[0] at t+4 with visited=0; one write of 1 to addr 5 at t+3. Repeat the request → visited=1 and no write.
- **Fairness:** all 4 processors hold valid continuously → grant order 0,1,2,3,0,… with grants 4 cycles apart. After that, only P1 and P3 valid with ptr=2 → P3 is granted first.
- **Same-address race:** P0 and P1 both request addr 7, memory clear → exactly one response has visited=0 (P0, granted first) and the other has visited=1. Exactly one write occurs.
- **Clear during an operation:** pulse clear at t+1 after accepting addr 9 → the response still arrives at t+4. CLEAR then writes 0 to addresses 0..1023 over 1024 cycles. `clear_busy_out` is high from t+2 until CLEAR ends, and no grants are issued during that interval. A subsequent request to 9 returns visited=0.
- **Reset mid-operation:** assert rst_in in WAIT → no resp_valid, no write. All outputs read 0 on the next cycle.
- **Address slicing:** P2 requests addr 1023 while the other lanes carry different addresses → `mem_addr_out` = 1023 during ISSUE through CHECK.
